// File: rtl/mux_pkg.sv
// Shared constants and helpers for the mux_arb_nbit stream multiplexer.
// The rotated first-one search is sized for up to MAX_M channels.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_ARB    = 1'b1;
    localparam int   MAX_M       = 64;

    // Index of the first set bit at or after base, wrapping at m; -1 if none.
    function automatic int first_one_rot(
        input logic [MAX_M-1:0] req,
        input int               base,
        input int               m
    );
        int  res;
        int  idx;
        logic found;
        res   = -1;
        found = 1'b0;
        for (int k = 0; k < MAX_M; k++) begin
            if (k < m && !found) begin
                idx = base + k;
                if (idx >= m) begin
                    idx = idx - m;
                end
                if (req[idx]) begin
                    found = 1'b1;
                    res   = idx;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter: round-robin from i_ptr with MUX_ARB_RR_EN defined,
// fixed lowest-index priority otherwise (i_ptr then has no effect).
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int M = 4
) (
    input  logic [M-1:0]         i_req,
    input  logic [$clog2(M)-1:0] i_ptr,
    input  logic                 i_en,
    output logic [M-1:0]         o_gnt,
    output logic [$clog2(M)-1:0] o_idx
);

    localparam int SW = $clog2(M);

`ifdef MUX_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic [SW-1:0]    w_base;
    logic [MAX_M-1:0] w_req;
    int               w_first;

    assign w_base = RR ? i_ptr : '0;

    always_comb begin
        w_req          = '0;
        w_req[M-1:0]   = i_req;
        w_first        = first_one_rot(w_req, int'(w_base), M);
        o_gnt          = '0;
        o_idx          = '0;
        if (i_en && w_first >= 0) begin
            o_gnt[w_first] = 1'b1;
            o_idx          = w_first[SW-1:0];
        end
    end

endmodule

// File: rtl/mux_arb_nbit.sv
// M-channel N-bit registered stream mux, manual select or arbitrated.
// MUX_ARB_RR_EN selects round-robin arbitration (default: fixed priority).
module mux_arb_nbit
    import mux_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [$clog2(M)-1:0] sel,
    input  logic [M*N-1:0]       in_data,
    input  logic [M-1:0]         in_valid,
    output logic [M-1:0]         in_ready,
    output logic [N-1:0]         out_data,
    output logic [$clog2(M)-1:0] out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int SW = $clog2(M);

    logic [SW-1:0] w_ptr;
    logic [SW-1:0] w_arb_idx;
    logic [SW-1:0] w_idx;
    logic [M-1:0]  w_arb_gnt;
    logic [M-1:0]  w_man_gnt;
    logic [M-1:0]  w_gnt;
    logic          w_load;
    logic          w_take;
    logic [N-1:0]  w_data;

    logic [N-1:0]  r_data;
    logic [SW-1:0] r_src;
    logic          r_valid;

    rr_arbiter #(.M(M)) u_arb (
        .i_req (in_valid),
        .i_ptr (w_ptr),
        .i_en  (mode == MODE_ARB),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx)
    );

    // Out-of-range sel matches no channel, so the grant is empty.
    always_comb begin
        w_man_gnt = '0;
        for (int i = 0; i < M; i++) begin
            w_man_gnt[i] = (sel == SW'(i)) && in_valid[i];
        end
    end

    assign w_gnt  = (mode == MODE_ARB) ? w_arb_gnt : w_man_gnt;
    assign w_idx  = (mode == MODE_ARB) ? w_arb_idx : sel;
    assign w_load = (!r_valid || out_ready) && !rst;
    assign w_take = (|w_gnt) && w_load;

    assign in_ready = w_gnt & {M{w_load}};

    always_comb begin
        w_data = '0;
        for (int i = 0; i < M; i++) begin
            if (w_gnt[i]) begin
                w_data = w_data | in_data[i*N +: N];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_src   <= '0;
            r_valid <= 1'b0;
        end else if (w_take) begin
            r_data  <= w_data;
            r_src   <= w_idx;
            r_valid <= 1'b1;
        end else if (w_load) begin
            r_valid <= 1'b0;
        end
    end

`ifdef MUX_ARB_RR_EN
    logic [SW-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_take && mode == MODE_ARB) begin
            r_ptr <= (w_arb_idx == SW'(M-1)) ? '0 : w_arb_idx + SW'(1);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    assign out_data  = r_data;
    assign out_src   = r_src;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_arb_nbit.sv
// Randomised bench for mux_arb_nbit with a behavioural reference model
// plus directed scenarios pinned by literal expectations.
module tb_mux_arb_nbit;

    localparam int N  = 8;
    localparam int M  = 4;
    localparam int SW = $clog2(M);

`ifdef MUX_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mode = 1'b0;
    logic [SW-1:0]  sel = '0;
    logic [M*N-1:0] in_data = '0;
    logic [M-1:0]   in_valid = '0;
    logic [M-1:0]   in_ready;
    logic [N-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           out_valid;
    logic           out_ready = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    logic          m_valid;
    logic [N-1:0]  m_data;
    int            m_src;
    int            m_ptr;

    mux_arb_nbit #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Channel the spec's grant rule picks right now, or -1.
    function automatic int model_grant();
        int base;
        int c;
        int r;
        r = -1;
        if (mode == 1'b0) begin
            if (int'(sel) < M && in_valid[sel]) r = int'(sel);
        end else begin
            base = RR ? m_ptr : 0;
            for (int k = 0; k < M; k++) begin
                c = (base + k) % M;
                if (in_valid[c] && r < 0) r = c;
            end
        end
        return r;
    endfunction

    function automatic logic [M-1:0] model_ready();
        int g;
        logic [M-1:0] r;
        g = model_grant();
        r = '0;
        if (!rst && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_src   <= 0;
            m_ptr   <= 0;
        end else begin
            g = model_grant();
            if (!m_valid || out_ready) begin
                if (g >= 0) begin
                    m_valid <= 1'b1;
                    m_data  <= in_data[g*N +: N];
                    m_src   <= g;
                    if (mode) m_ptr <= (g + 1) % M;
                end else begin
                    m_valid <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_valid", 32'(out_valid), 32'(m_valid));
        chk("model_data",  32'(out_data),  32'(m_data));
        chk("model_src",   32'(out_src),   32'(m_src));
        chk("model_ready", 32'(in_ready),  32'(model_ready()));
    end

    task automatic set_inputs(input logic md, input int s,
                              input logic [M-1:0] v, input logic ordy);
        mode      = md;
        sel       = SW'(s);
        in_valid  = v;
        out_ready = ordy;
    endtask

    initial begin
        in_data  = $urandom();
        in_valid = 4'($urandom());
        mode     = 1'($urandom());
        sel      = SW'($urandom());
        out_ready = 1'($urandom());
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_src",   32'(out_src),   32'd0);
        chk("rst_ready", 32'(in_ready),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // manual select of channel 2
        in_data = 32'h3C_A5_00_11;
        set_inputs(1'b0, 2, 4'b0100, 1'b1);
        @(posedge clk); #2;
        chk("man_data",  32'(out_data),  32'hA5);
        chk("man_src",   32'(out_src),   32'd2);
        chk("man_valid", 32'(out_valid), 32'd1);
        sel = 2'd3;
        #1;
        chk("man_sel3_ready", 32'(in_ready), 32'd0);

        // all valid, arbitrated: round-robin or fixed priority
        in_data = 32'h44_33_22_11;
        set_inputs(1'b1, 0, 4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #2;
            chk("arb_seq_src", 32'(out_src), RR ? 32'(k % 4) : 32'd0);
        end

        // backpressure for three cycles
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            chk("bp_src",   32'(out_src),   RR ? 32'd3 : 32'd0);
            chk("bp_data",  32'(out_data),  RR ? 32'h44 : 32'h11);
            chk("bp_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'b0001);
        @(posedge clk); #2;
        chk("bp_nobubble_valid", 32'(out_valid), 32'd1);
        chk("bp_nobubble_src",   32'(out_src),   32'd0);

        // sparse requests with wrap from ptr 3
        in_valid = 4'b0100;
        @(posedge clk); #2;
        chk("sparse_pre_src", 32'(out_src), 32'd2);
        in_valid = 4'b0011;
        #1;
        chk("sparse_first", 32'(in_ready), 32'b0001);
        @(posedge clk); #2;
        chk("sparse_second", 32'(in_ready), RR ? 32'b0010 : 32'b0001);

        // reset while output is stalled
        in_valid  = 4'b0100;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 4'b0000;
        @(posedge clk); #1;
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_inputs(1'b1, 0, 4'b1111, 1'b1);
        #1;
        chk("mid_ptr_zero", 32'(in_ready), 32'b0001);

        // randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_data   = $urandom();
            in_valid  = 4'($urandom());
            mode      = ($urandom_range(0, 3) != 0);
            sel       = SW'($urandom());
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end
        end

        @(posedge clk); #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
